// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over the shared datapath.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of executing as NOPs.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       mdr_we,
  output logic [2:0] imm_type,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       instr_retired,
  output logic       mem_fault,
  output logic       illegal_instr
);

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
`endif

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

  localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [2:0]           imm_q, imm_nxt;
  logic                 waiting, timed_out;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);

  // Counter holds the number of consecutive not-ready cycles already spent in FETCH/MEM;
  // a ready in the timeout cycle still completes normally.
  assign waiting   = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
  assign timed_out = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      imm_q    <= '0;
    end else begin
      state <= state_nxt;
      imm_q <= imm_nxt;
      if ((MEM_TIMEOUT != 0) && waiting && !timed_out)
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    imm_nxt       = imm_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 2'd0;
    reg_we        = 1'b0;
    wb_sel        = 2'd0;
    instr_retired = 1'b0;
    mem_fault     = 1'b0;
    illegal_instr = 1'b0;
    imm_type      = imm_q;

    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end else if (timed_out) begin
          mem_fault = 1'b1;
          state_nxt = FETCH;
        end
      end
      DECODE: begin
        if (is_store)                imm_nxt = 3'd1;
        else if (is_branch)          imm_nxt = 3'd2;
        else if (is_lui || is_auipc) imm_nxt = 3'd3;
        else if (is_jal)             imm_nxt = 3'd4;
        else                         imm_nxt = 3'd0;
        state_nxt = EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (!(is_lui || is_auipc || is_jal || is_jalr || is_branch || is_load || is_store ||
              is_opimm || is_op || (opcode == OPC_FENCE) || (opcode == OPC_SYSTEM)))
          state_nxt = TRAP;
`endif
      end
      EXEC: begin
        alu_a_sel = is_auipc || is_branch || is_jal;
        alu_b_sel = !(is_op || is_branch);
        if (is_load || is_store) begin
          state_nxt = MEM;
        end else if (is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr) begin
          state_nxt = WB;
        end else begin
          // Branches, FENCE/SYSTEM and (without trapping) unknown opcodes all retire here.
          pc_we         = 1'b1;
          pc_src        = (is_branch && branch_taken) ? 2'd1 : 2'd0;
          instr_retired = 1'b1;
          state_nxt     = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_nxt     = FETCH;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = WB;
          end
        end else if (timed_out) begin
          mem_fault = 1'b1;
          state_nxt = FETCH;
        end
      end
      WB: begin
        reg_we        = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        wb_sel        = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_src        = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        state_nxt     = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegal_instr = 1'b1;
      end
`endif
      default: state_nxt = FETCH;
    endcase

    // State only resets on the clock edge, so outputs are forced quiet for the whole reset cycle.
    if (rst) begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      alu_a_sel     = 1'b0;
      alu_b_sel     = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 2'd0;
      reg_we        = 1'b0;
      wb_sel        = 2'd0;
      instr_retired = 1'b0;
      mem_fault     = 1'b0;
      illegal_instr = 1'b0;
      imm_type      = 3'd0;
    end
  end

endmodule
